// File: rtl/pattern_step_ctrl.sv
// Step sequencer controller: tempo divider, step/bar counter and a one-deep pattern slot
// that reloads a downstream rotator at bar boundaries. Optional swing timing: PATTERN_STEP_SWING_EN.
module pattern_step_ctrl #(
  parameter int               DEPTH        = 16,
  parameter int               DIV_W        = 16,
  parameter logic [DEPTH-1:0] INIT_PATTERN = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       run,
  input  logic [DIV_W-1:0]           div,
`ifdef PATTERN_STEP_SWING_EN
  input  logic [DIV_W-1:0]           swing,
`endif
  input  logic [$clog2(DEPTH):0]     len,
  input  logic                       pat_valid,
  input  logic [DEPTH-1:0]           pat_data,
  output logic                       pat_ready,
  output logic                       rot_ena,
  output logic                       rot_load,
  output logic [DEPTH-1:0]           rot_pattern,
  output logic [$clog2(DEPTH)-1:0]   step,
  output logic                       bar
);

  localparam int SW = $clog2(DEPTH);
  localparam int LW = SW + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] tick_q, tick_d;
  logic [SW-1:0]    step_q, step_d;
  logic             ena_q, ena_d;
  logic             load_q, load_d;
  logic             bar_q, bar_d;
  logic             pend_valid_q, pend_valid_d;
  logic [DEPTH-1:0] pend_data_q, pend_data_d;
  logic [DEPTH-1:0] pattern_q, pattern_d;

  logic [LW-1:0]    last_step;
  logic             at_last;
  logic [DIV_W-1:0] limit;
  logic             terminal;
  logic             do_transfer;

  // Out-of-range lengths fall back to the full pattern width.
  always_comb begin
    if (len == '0 || len > LW'(DEPTH))
      last_step = LW'(DEPTH - 1);
    else
      last_step = len - LW'(1);
  end

  assign at_last = {1'b0, step_q} >= last_step;

`ifdef PATTERN_STEP_SWING_EN
  logic [DIV_W:0]   swing_sum;
  logic [DIV_W-1:0] swing_lim;

  // Intervals leading into an odd step are stretched by swing, saturating.
  always_comb begin
    swing_sum = {1'b0, div} + {1'b0, swing};
    swing_lim = swing_sum[DIV_W] ? '1 : swing_sum[DIV_W-1:0];
    limit     = (!at_last && !step_q[0]) ? swing_lim : div;
  end
`else
  assign limit = div;
`endif

  assign terminal = tick_q >= limit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      tick_q       <= '0;
      step_q       <= '0;
      ena_q        <= 1'b0;
      load_q       <= 1'b0;
      bar_q        <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_data_q  <= '0;
      pattern_q    <= INIT_PATTERN;
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      step_q       <= step_d;
      ena_q        <= ena_d;
      load_q       <= load_d;
      bar_q        <= bar_d;
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
      pattern_q    <= pattern_d;
    end
  end

  // Pulses are computed one cycle ahead so every output leaves a flop.
  always_comb begin
    state_d      = state_q;
    tick_d       = tick_q;
    step_d       = step_q;
    ena_d        = 1'b0;
    load_d       = 1'b0;
    bar_d        = 1'b0;
    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;
    pattern_d    = pattern_q;
    do_transfer  = 1'b0;

    case (state_q)
      IDLE: begin
        tick_d      = '0;
        step_d      = '0;
        do_transfer = 1'b1;
        if (run) begin
          state_d = RUN;
          load_d  = 1'b1;
        end
      end
      RUN: begin
        if (!run) begin
          state_d = IDLE;
          tick_d  = '0;
          step_d  = '0;
        end else if (terminal) begin
          tick_d = '0;
          if (at_last) begin
            step_d      = '0;
            load_d      = 1'b1;
            bar_d       = 1'b1;
            do_transfer = 1'b1;
          end else begin
            step_d = step_q + SW'(1);
            ena_d  = 1'b1;
          end
        end else begin
          tick_d = tick_q + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // A pattern captured on this edge only becomes eligible at the next reload.
    if (do_transfer && pend_valid_q) begin
      pattern_d    = pend_data_q;
      pend_valid_d = 1'b0;
    end else if (pat_valid && !pend_valid_q) begin
      pend_valid_d = 1'b1;
      pend_data_d  = pat_data;
    end
  end

  assign pat_ready   = ~pend_valid_q;
  assign rot_ena     = ena_q;
  assign rot_load    = load_q;
  assign bar         = bar_q;
  assign step        = step_q;
  assign rot_pattern = pattern_q;

endmodule

// File: tb/tb_pattern_step_ctrl.sv
// Directed self-checking bench for pattern_step_ctrl: table-driven timing vectors plus
// hand-written pattern-slot, run-drop and reset sequences.
module tb_pattern_step_ctrl;

  localparam int               DEPTH = 16;
  localparam int               DIV_W = 16;
  localparam logic [DEPTH-1:0] INIT  = 16'hA5A5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             run = 1'b0;
  logic [DIV_W-1:0] div = '0;
  logic [4:0]       len = '0;
  logic             pat_valid = 1'b0;
  logic [DEPTH-1:0] pat_data = '0;
  logic             pat_ready;
  logic             rot_ena;
  logic             rot_load;
  logic [DEPTH-1:0] rot_pattern;
  logic [3:0]       step;
  logic             bar;
`ifdef PATTERN_STEP_SWING_EN
  logic [DIV_W-1:0] swing = '0;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  pattern_step_ctrl #(.DEPTH(DEPTH), .DIV_W(DIV_W), .INIT_PATTERN(INIT)) dut (
    .clk(clk), .rst(rst), .run(run), .div(div),
`ifdef PATTERN_STEP_SWING_EN
    .swing(swing),
`endif
    .len(len), .pat_valid(pat_valid), .pat_data(pat_data), .pat_ready(pat_ready),
    .rot_ena(rot_ena), .rot_load(rot_load), .rot_pattern(rot_pattern),
    .step(step), .bar(bar)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             rst;
    logic             run;
    logic [DIV_W-1:0] div;
    logic [4:0]       len;
    logic             ena;
    logic             load;
    logic             bar;
    logic [3:0]       step;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkVec(input logic r, input logic rn, input logic [DIV_W-1:0] d,
                                 input logic [4:0] l, input logic e, input logic ld,
                                 input logic b, input logic [3:0] s);
    vec_t v;
    v.rst = r; v.run = rn; v.div = d; v.len = l;
    v.ena = e; v.load = ld; v.bar = b; v.step = s;
    return v;
  endfunction

  task automatic tickClk();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic runTo(input int target);
    while (cyc < target) tickClk();
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst = v.rst;
    run = v.run;
    div = v.div;
    len = v.len;
    tickClk();
  endtask

  // Full-width wrap for div=0: load at 0, a step every cycle, load+bar after 16 steps.
  task automatic addFullWidthSegment(input logic [4:0] l);
    vecs.push_back(mkVec(1'b1, 1'b1, 16'd0, l, 1'b0, 1'b0, 1'b0, 4'd0));
    for (int c = 0; c <= 16; c++)
      vecs.push_back(mkVec(1'b0, 1'b1, 16'd0, l, (c >= 1 && c <= 15), (c == 0 || c == 16),
                           (c == 16), 4'(c % 16)));
  endtask

  initial begin
    vec_t v;

    // div=3, len=4: load at 0, ena at 4/8/12, load+bar at 16, step = cycle/4.
    vecs.push_back(mkVec(1'b1, 1'b1, 16'd3, 5'd4, 1'b0, 1'b0, 1'b0, 4'd0));
    for (int c = 0; c <= 16; c++)
      vecs.push_back(mkVec(1'b0, 1'b1, 16'd3, 5'd4, (c == 4 || c == 8 || c == 12),
                           (c == 0 || c == 16), (c == 16), 4'((c / 4) % 4)));
    addFullWidthSegment(5'd0);
    addFullWidthSegment(5'd20);
    // div=0, len=1: entry load without bar, then load+bar every cycle.
    vecs.push_back(mkVec(1'b1, 1'b1, 16'd0, 5'd1, 1'b0, 1'b0, 1'b0, 4'd0));
    for (int c = 0; c <= 5; c++)
      vecs.push_back(mkVec(1'b0, 1'b1, 16'd0, 5'd1, 1'b0, 1'b1, (c != 0), 4'd0));

    #2;
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      applyStimulus(v);
      checkOutput($sformatf("vec%0d", i), {28'd0, rot_ena, rot_load, bar, 1'b0},
                  {28'd0, v.ena, v.load, v.bar, 1'b0});
      checkOutput($sformatf("vec%0d_step", i), {28'd0, step}, {28'd0, v.step});
    end

    // Pattern slot: mid-bar offer, then offer on the wrap edge, then ignored second offer.
    rst = 1'b1; run = 1'b1; div = 16'd3; len = 5'd4;
    tickClk();
    checkOutput("rst_pattern", {16'd0, rot_pattern}, {16'd0, INIT});
    checkOutput("rst_ready", {31'd0, pat_ready}, 32'd1);
    rst = 1'b0;
    cyc = -1;
    tickClk();
    checkOutput("entry_load", {31'd0, rot_load}, 32'd1);
    runTo(20);
    pat_valid = 1'b1; pat_data = 16'hF0F0;
    tickClk();
    pat_valid = 1'b0;
    checkOutput("capture_ready", {31'd0, pat_ready}, 32'd0);
    checkOutput("capture_hold", {16'd0, rot_pattern}, {16'd0, INIT});
    runTo(32);
    checkOutput("wrap32_load", {30'd0, rot_load, bar}, 32'd3);
    checkOutput("wrap32_pattern", {16'd0, rot_pattern}, 32'hF0F0);
    checkOutput("wrap32_ready", {31'd0, pat_ready}, 32'd1);
    runTo(47);
    pat_valid = 1'b1; pat_data = 16'h1234;
    tickClk();
    checkOutput("wrap48_bar", {31'd0, bar}, 32'd1);
    checkOutput("wrap48_pattern", {16'd0, rot_pattern}, 32'hF0F0);
    checkOutput("wrap48_ready", {31'd0, pat_ready}, 32'd0);
    pat_data = 16'hBEEF;
    tickClk();
    pat_valid = 1'b0;
    runTo(64);
    checkOutput("wrap64_bar", {31'd0, bar}, 32'd1);
    checkOutput("wrap64_pattern", {16'd0, rot_pattern}, 32'h1234);
    checkOutput("wrap64_ready", {31'd0, pat_ready}, 32'd1);
    runTo(80);
    checkOutput("wrap80_pattern", {16'd0, rot_pattern}, 32'h1234);

    // IDLE transfer without rot_load, then run drop at step 2 and re-entry.
    rst = 1'b1; run = 1'b0; div = 16'd7; len = 5'd4;
    tickClk();
    rst = 1'b0;
    pat_valid = 1'b1; pat_data = 16'h00FF;
    tickClk();
    pat_valid = 1'b0;
    tickClk();
    checkOutput("idle_pattern", {16'd0, rot_pattern}, 32'h00FF);
    checkOutput("idle_ready", {31'd0, pat_ready}, 32'd1);
    checkOutput("idle_noload", {31'd0, rot_load}, 32'd0);
    run = 1'b1;
    cyc = -1;
    tickClk();
    checkOutput("run2_load", {31'd0, rot_load}, 32'd1);
    runTo(17);
    checkOutput("run2_step2", {28'd0, step}, 32'd2);
    run = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tickClk();
      checkOutput($sformatf("drop%0d", k), {27'd0, rot_ena, rot_load, bar, step[1:0]}, 32'd0);
    end
    checkOutput("drop_step", {28'd0, step}, 32'd0);
    run = 1'b1;
    tickClk();
    checkOutput("rerun_load", {31'd0, rot_load}, 32'd1);
    checkOutput("rerun_pattern", {16'd0, rot_pattern}, 32'h00FF);
    runTo(cyc + 10);
    checkOutput("pre_rst_step", {28'd0, step}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_step", {28'd0, step}, 32'd0);
    checkOutput("async_rst_pattern", {16'd0, rot_pattern}, {16'd0, INIT});
    #1;
    rst = 1'b0;

`ifdef PATTERN_STEP_SWING_EN
    // div=3, swing=2: 6 cycles into odd steps, 4 into even ones.
    rst = 1'b1; run = 1'b1; div = 16'd3; swing = 16'd2; len = 5'd4;
    tickClk();
    rst = 1'b0;
    cyc = -1;
    for (int c = 0; c <= 20; c++) begin
      tickClk();
      checkOutput($sformatf("swing%0d", c), {29'd0, rot_ena, rot_load, bar},
                  {29'd0, (c == 6 || c == 10 || c == 16), (c == 0 || c == 20), (c == 20)});
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pattern_step_ctrl.md
PATTERN_STEP_CTRL -- requirements
Module: pattern_step_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 16: pattern width in steps, minimum 2.
REQ-002 SHALL have parameter DIV_W, default 16: tempo divider width.
REQ-003 SHALL have parameter INIT_PATTERN, default all-zero (DEPTH bits): pattern loaded on reset.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state on rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port run, input, 1 bit: level; 1 = sequencing active.
REQ-007 SHALL have port div, input, DIV_W bits: clock cycles per step minus 1.
REQ-008 SHALL have port len, input, $clog2(DEPTH)+1 bits: active steps per bar, 1..DEPTH; 0 or >DEPTH treated as DEPTH.
REQ-009 SHALL have port pat_valid, input, 1 bit: new pattern offered.
REQ-010 SHALL have port pat_data, input, DEPTH bits: offered pattern.
REQ-011 SHALL have port pat_ready, output, 1 bit: pending slot empty.
REQ-012 SHALL have port rot_ena, output, 1 bit: one-cycle rotate-enable pulse to the rotator.
REQ-013 SHALL have port rot_load, output, 1 bit: one-cycle reload pulse to the rotator.
REQ-014 SHALL have port rot_pattern, output, DEPTH bits: pattern to be loaded on rot_load.
REQ-015 SHALL have port step, output, $clog2(DEPTH) bits: current step index.
REQ-016 SHALL have port bar, output, 1 bit: one-cycle pulse at bar wrap.

Function
REQ-017 SHALL implement FSM states IDLE and RUN; IDLE->RUN when run=1, RUN->IDLE when run=0 (next cycle).
REQ-018 In IDLE: tick counter=0, step=0, rot_ena=0, bar=0.
REQ-019 On IDLE->RUN transition, rot_load SHALL pulse in the first RUN cycle; tick counter starts at 0 in that cycle.
REQ-020 In RUN, tick counter increments each cycle; terminal when tick>=div (>= so a lowered div ends the interval at once); on terminal tick resets to 0.
REQ-021 On terminal with step<L-1 (L=effective len): rot_ena pulses 1 cycle, step increments.
REQ-022 On terminal with step>=L-1: step<=0, rot_load and bar pulse 1 cycle, rot_ena stays 0 (rot_ena and rot_load never both 1).
REQ-023 div=0 SHALL give a step every cycle; L=1 SHALL give rot_load+bar every terminal tick.
REQ-024 pat_ready = 1 iff pending slot empty; pat_valid&pat_ready captures pat_data into pending slot.
REQ-025 Pending pattern SHALL transfer to rot_pattern in the same cycle rot_load pulses (bar wrap or RUN entry), emptying the slot; in IDLE it transfers on the next cycle without rot_load.
REQ-026 Capture coinciding with a bar wrap SHALL NOT apply at that wrap; it applies at the following one.
REQ-027 pat_valid while pat_ready=0 SHALL be ignored (no overwrite); offerer must hold.
REQ-028 run dropping mid-bar SHALL discard tick/step progress but keep rot_pattern and pending slot.

Reset
REQ-029 rst SHALL asynchronously force: IDLE, tick=0, step=0, rot_ena=0, rot_load=0, bar=0, pending empty, pat_ready=1, rot_pattern=INIT_PATTERN.
REQ-030 rst asserted mid-bar SHALL abandon the bar; after release, sequencing restarts per REQ-019 if run=1.

Configuration
REQ-031 With macro PATTERN_STEP_SWING_EN defined, SHALL add input swing (DIV_W bits); the interval ending on an odd step index SHALL terminate at tick>=div+swing (saturating at all-ones), even steps at tick>=div.
REQ-032 Without PATTERN_STEP_SWING_EN, port swing SHALL be absent and every interval SHALL be div+1 cycles.

Verification
REQ-033 Reset, run=1, div=3, len=4 -> rot_load at cycle 0; rot_ena at cycles 4, 8, 12; rot_load+bar at 16; step 0,1,2,3,0.
REQ-034 Offer pat_data=0xF0F0 mid-bar -> pat_ready drops next cycle; rot_pattern becomes 0xF0F0 with next rot_load; pat_ready returns 1 after.
REQ-035 pat_valid on same cycle as bar wrap with 0x1234 -> not applied at that wrap; applied at next wrap; second offer while full ignored.
REQ-036 div=0, len=1 -> rot_load and bar every cycle, rot_ena never asserts.
REQ-037 run=1, div=7; run=0 at step 2 -> step=0, no pulses; run=1 again -> rot_load, rot_pattern unchanged.
REQ-038 PATTERN_STEP_SWING_EN, div=3, swing=2 -> step intervals alternate 6 (into odd) and 4 (into even) cycles.
